// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA game blocks.
//   Screen geometry, coordinate/speed widths and the motion FSM encoding.
//   No ports: imported with "import vga_game_pkg::*;".
package vga_game_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BORDER   = 10;
  localparam int OBJ_SIZE = 30;
  localparam int SPEED_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    CRUISE = 2'd2
  } motion_state_t;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a stability debouncer for one
// active-low mechanical switch.
// Ports:
//   clk     in  1  system clock
//   rst     in  1  synchronous reset, active-high (switch forced released)
//   raw_n   in  1  raw switch, active-low, asynchronous
//   pressed out 1  debounced switch state, 1 = pressed
// A change of the synchronized input is accepted only after it has been
// stable for DB_CYCLES consecutive clocks; any return to the accepted level
// clears the count, so short glitches never reach the output.
module switch_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             accepted_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      accepted_n <= 1'b1;
      cnt        <= '0;
    end else begin
      // stage p0/p1: metastability filter
      sync_p0 <= raw_n;
      sync_p1 <= sync_p0;
      // debounce stage: count consecutive cycles of disagreement
      if (sync_p1 == accepted_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        accepted_n <= sync_p1;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = ~accepted_n;

endmodule

// File: rtl/object_motion_ctrl.sv
// Motion controller for the game object.
//   Debounces the four direction switches, detects the falling edge of
//   vsync and, on that single-cycle tick, advances a ramp/cruise speed FSM
//   and moves the object, clamped inside the screen border.
// Ports:
//   CLK          in  1   system clock (shared with vga timing)
//   RST          in  1   synchronous reset, active-high
//   VS           in  1   vsync, active-low, treated as asynchronous
//   up_switch    in  1   active-low raw switch
//   dn_switch    in  1   active-low raw switch
//   left_switch  in  1   active-low raw switch
//   right_switch in  1   active-low raw switch
//   o_x          out 10  object x (top-left corner), registered
//   o_y          out 10  object y (top-left corner), registered
//   moving       out 1   high whenever the FSM is not IDLE
//   speed        out 3   pixels per frame, 0 in IDLE
module object_motion_ctrl
  import vga_game_pkg::*;
#(
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int X_MIN        = BORDER,
  parameter int X_MAX        = SCREEN_W - BORDER - OBJ_SIZE,
  parameter int Y_MIN        = BORDER,
  parameter int Y_MAX        = SCREEN_H - BORDER - OBJ_SIZE,
  parameter int DB_CYCLES    = 50000,
  parameter int ACCEL_FRAMES = 8,
  parameter int MAX_SPEED    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VS,
  input  logic               up_switch,
  input  logic               dn_switch,
  input  logic               left_switch,
  input  logic               right_switch,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               moving,
  output logic [SPEED_W-1:0] speed
);

  localparam int FC_W = $clog2(ACCEL_FRAMES + 1);
  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(ACCEL_FRAMES - 1);
  localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPD_ONE = SPEED_W'(1);
  localparam logic signed [COORD_W:0] XLO = (COORD_W + 1)'(X_MIN);
  localparam logic signed [COORD_W:0] XHI = (COORD_W + 1)'(X_MAX);
  localparam logic signed [COORD_W:0] YLO = (COORD_W + 1)'(Y_MIN);
  localparam logic signed [COORD_W:0] YHI = (COORD_W + 1)'(Y_MAX);
  // With a one-pixel ceiling there is nothing to ramp through.
  localparam motion_state_t ENTRY_STATE = (MAX_SPEED == 1) ? CRUISE : RAMP;

  // Move one axis by +/-spd in 11-bit signed and saturate to [lo,hi].
  function automatic logic [COORD_W-1:0] step_clamp(
    input logic [COORD_W-1:0]        pos,
    input logic signed [1:0]         dir,
    input logic [SPEED_W-1:0]        spd,
    input logic signed [COORD_W:0]   lo,
    input logic signed [COORD_W:0]   hi
  );
    logic signed [COORD_W:0] base;
    logic signed [COORD_W:0] delta;
    logic signed [COORD_W:0] sum;
    base  = $signed({1'b0, pos});
    delta = $signed({{(COORD_W + 1 - SPEED_W){1'b0}}, spd});
    if (dir == 2'sd1)       sum = base + delta;
    else if (dir == -2'sd1) sum = base - delta;
    else                    sum = base;
    if (sum < lo)      step_clamp = lo[COORD_W-1:0];
    else if (sum > hi) step_clamp = hi[COORD_W-1:0];
    else               step_clamp = sum[COORD_W-1:0];
  endfunction

  logic up_pr, dn_pr, left_pr, right_pr;

  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(CLK), .rst(RST), .raw_n(up_switch), .pressed(up_pr));
  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(CLK), .rst(RST), .raw_n(dn_switch), .pressed(dn_pr));
  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk(CLK), .rst(RST), .raw_n(left_switch), .pressed(left_pr));
  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk(CLK), .rst(RST), .raw_n(right_switch), .pressed(right_pr));

  logic vs_p0, vs_p1, vs_p2;
  logic tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_p0 <= 1'b1;
      vs_p1 <= 1'b1;
      vs_p2 <= 1'b1;
    end else begin
      // stage p0/p1: synchronizer, p2: previous value for edge detect
      vs_p0 <= VS;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  assign tick = vs_p2 & ~vs_p1;

  logic signed [1:0]  dx, dy;
  logic signed [1:0]  last_dx, last_dy;
  logic               any_dir;
  logic               restart;
  logic               ramp_up;
  logic [SPEED_W-1:0] move_speed;
  logic [FC_W-1:0]    frame_cnt;
  motion_state_t      state;

  always_comb begin
    dx = 2'sd0;
    if (right_pr && !left_pr)      dx = 2'sd1;
    else if (left_pr && !right_pr) dx = -2'sd1;
    dy = 2'sd0;
    if (dn_pr && !up_pr)           dy = 2'sd1;
    else if (up_pr && !dn_pr)      dy = -2'sd1;
  end

  // Speed used for this tick's move. A completed acceleration period moves
  // with the raised speed straight away; a new or changed vector restarts
  // at one pixel per frame.
  always_comb begin
    any_dir = (dx != 2'sd0) || (dy != 2'sd0);
    restart = any_dir && ((state == IDLE) || (dx != last_dx) || (dy != last_dy));
    ramp_up = (state == RAMP) && (frame_cnt == FC_LAST);
    if (!any_dir)              move_speed = '0;
    else if (restart)          move_speed = SPD_ONE;
    else if (state == CRUISE)  move_speed = SPD_MAX;
    else if (ramp_up)          move_speed = speed + 1'b1;
    else                       move_speed = speed;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      frame_cnt <= '0;
      speed     <= '0;
      moving    <= 1'b0;
      last_dx   <= 2'sd0;
      last_dy   <= 2'sd0;
      o_x       <= COORD_W'(X_INIT);
      o_y       <= COORD_W'(Y_INIT);
    end else if (tick) begin
      // frame update: state, speed and position change only here
      speed   <= move_speed;
      o_x     <= step_clamp(o_x, dx, move_speed, XLO, XHI);
      o_y     <= step_clamp(o_y, dy, move_speed, YLO, YHI);
      last_dx <= dx;
      last_dy <= dy;
      if (!any_dir) begin
        state     <= IDLE;
        moving    <= 1'b0;
        frame_cnt <= '0;
      end else if (restart) begin
        state     <= ENTRY_STATE;
        moving    <= 1'b1;
        frame_cnt <= '0;
      end else begin
        case (state)
          RAMP: begin
            if (ramp_up) begin
              frame_cnt <= '0;
              if (move_speed >= SPD_MAX) state <= CRUISE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_object_motion_ctrl.sv
module tb_object_motion_ctrl;

  localparam int DB   = 4;
  localparam int ACC  = 2;
  localparam int MAXS = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       VS = 1'b1;
  logic       up_switch = 1'b1;
  logic       dn_switch = 1'b1;
  logic       left_switch = 1'b1;
  logic       right_switch = 1'b1;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       moving;
  logic [2:0] speed;

  int total = 0;
  int bad = 0;

  // reference model state: position, consecutive held ticks, last vector
  int mx, my, mspd, mheld, mldx, mldy;

  object_motion_ctrl #(
    .DB_CYCLES(DB), .ACCEL_FRAMES(ACC), .MAX_SPEED(MAXS)
  ) dut (
    .CLK(CLK), .RST(RST), .VS(VS),
    .up_switch(up_switch), .dn_switch(dn_switch),
    .left_switch(left_switch), .right_switch(right_switch),
    .o_x(o_x), .o_y(o_y), .moving(moving), .speed(speed)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    mx = 320; my = 240; mspd = 0; mheld = 0; mldx = 0; mldy = 0;
  endfunction

  // Speed is 1 + one step per ACC consecutive frames holding the same
  // vector, capped at MAXS.
  function automatic void model_tick();
    int dx, dy;
    dx = (right_switch ? 0 : 1) - (left_switch ? 0 : 1);
    dy = (dn_switch ? 0 : 1) - (up_switch ? 0 : 1);
    if (dx == 0 && dy == 0) begin
      mheld = 0;
      mspd  = 0;
    end else begin
      if (mheld > 0 && dx == mldx && dy == mldy) mheld++;
      else mheld = 1;
      mspd = 1 + (mheld - 1) / ACC;
      if (mspd > MAXS) mspd = MAXS;
      mx = clampi(mx + dx * mspd, 10, 600);
      my = clampi(my + dy * mspd, 10, 440);
    end
    mldx = dx;
    mldy = dy;
  endfunction

  task automatic do_reset();
    up_switch = 1; dn_switch = 1; left_switch = 1; right_switch = 1; VS = 1;
    repeat (2) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    model_reset();
  endtask

  // arguments are "pressed" flags
  task automatic set_sw(input bit u, input bit d, input bit l, input bit r);
    up_switch = ~u; dn_switch = ~d; left_switch = ~l; right_switch = ~r;
    repeat (10) @(negedge CLK);
  endtask

  task automatic frame();
    @(negedge CLK);
    VS = 0;
    repeat (8) @(negedge CLK);
    VS = 1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic glitch(input int idx);
    @(negedge CLK);
    case (idx)
      0: up_switch = ~up_switch;
      1: dn_switch = ~dn_switch;
      2: left_switch = ~left_switch;
      default: right_switch = ~right_switch;
    endcase
    repeat (3) @(negedge CLK);
    case (idx)
      0: up_switch = ~up_switch;
      1: dn_switch = ~dn_switch;
      2: left_switch = ~left_switch;
      default: right_switch = ~right_switch;
    endcase
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (o_x !== 10'd320 || o_y !== 10'd240 || speed !== 3'd0 || moving !== 1'b0) begin
      bad++;
      $display("FAIL reset: got x=%0d y=%0d spd=%0d mv=%0b want x=320 y=240 spd=0 mv=0",
               o_x, o_y, speed, moving);
    end
    for (int i = 0; i < 2; i++) begin
      frame();
      model_tick();
      total++;
      if (o_x !== 10'(mx) || o_y !== 10'(my) || speed !== 3'(mspd) || moving !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle_tick %0d: got x=%0d y=%0d spd=%0d mv=%0b want x=%0d y=%0d spd=%0d mv=0",
                 i, o_x, o_y, speed, moving, mx, my, mspd);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    glitch(3);
    frame();
    model_tick();
    total++;
    if (o_x !== 10'd320 || moving !== 1'b0 || speed !== 3'd0) begin
      bad++;
      $display("FAIL bounce_glitch: got x=%0d spd=%0d mv=%0b want x=320 spd=0 mv=0",
               o_x, speed, moving);
    end
    set_sw(0, 0, 0, 1);
    frame();
    model_tick();
    total++;
    if (o_x !== 10'd321 || o_y !== 10'd240 || moving !== 1'b1 || speed !== 3'd1) begin
      bad++;
      $display("FAIL bounce_accept: got x=%0d y=%0d spd=%0d mv=%0b want x=321 y=240 spd=1 mv=1",
               o_x, o_y, speed, moving);
    end
    // no vsync edge: position must not change while the switch stays held
    repeat (40) @(negedge CLK);
    total++;
    if (o_x !== 10'(mx) || o_y !== 10'(my) || speed !== 3'(mspd)) begin
      bad++;
      $display("FAIL vs_frozen: got x=%0d y=%0d spd=%0d want x=%0d y=%0d spd=%0d",
               o_x, o_y, speed, mx, my, mspd);
    end
  endtask

  task automatic test_ramp();
    int ex[6];
    int es[6];
    ex = '{321, 322, 324, 326, 329, 332};
    es = '{1, 1, 2, 2, 3, 3};
    do_reset();
    set_sw(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      frame();
      model_tick();
      total++;
      if (o_x !== 10'(ex[i]) || speed !== 3'(es[i]) || o_x !== 10'(mx) || moving !== 1'b1) begin
        bad++;
        $display("FAIL ramp tick %0d: got x=%0d spd=%0d mv=%0b want x=%0d spd=%0d mv=1",
                 i, o_x, speed, moving, ex[i], es[i]);
      end
    end
    set_sw(0, 0, 0, 0);
    frame();
    model_tick();
    total++;
    if (o_x !== 10'd332 || speed !== 3'd0 || moving !== 1'b0) begin
      bad++;
      $display("FAIL ramp_release: got x=%0d spd=%0d mv=%0b want x=332 spd=0 mv=0",
               o_x, speed, moving);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    set_sw(0, 0, 0, 1);
    for (int i = 0; i < 95; i++) begin
      frame();
      model_tick();
      total++;
      if (o_x !== 10'(mx) || o_y !== 10'(my) || speed !== 3'(mspd) || moving !== 1'b1) begin
        bad++;
        $display("FAIL clamp_run tick %0d: got x=%0d y=%0d spd=%0d mv=%0b want x=%0d y=%0d spd=%0d mv=1",
                 i, o_x, o_y, speed, moving, mx, my, mspd);
      end
    end
    total++;
    if (o_x !== 10'd599 || speed !== 3'd3) begin
      bad++;
      $display("FAIL clamp_at599: got x=%0d spd=%0d want x=599 spd=3", o_x, speed);
    end
    for (int i = 0; i < 2; i++) begin
      frame();
      model_tick();
      total++;
      if (o_x !== 10'd600 || o_x !== 10'(mx) || speed !== 3'd3 || moving !== 1'b1) begin
        bad++;
        $display("FAIL clamp_sat %0d: got x=%0d spd=%0d mv=%0b want x=600 spd=3 mv=1",
                 i, o_x, speed, moving);
      end
    end
    set_sw(0, 0, 1, 1);
    frame();
    model_tick();
    total++;
    if (o_x !== 10'd600 || o_y !== 10'd240 || speed !== 3'd0 || moving !== 1'b0) begin
      bad++;
      $display("FAIL clamp_opposite: got x=%0d y=%0d spd=%0d mv=%0b want x=600 y=240 spd=0 mv=0",
               o_x, o_y, speed, moving);
    end
  endtask

  task automatic test_diag();
    do_reset();
    set_sw(1, 0, 1, 0);
    frame();
    model_tick();
    total++;
    if (o_x !== 10'd319 || o_y !== 10'd239 || speed !== 3'd1 || moving !== 1'b1) begin
      bad++;
      $display("FAIL diag: got x=%0d y=%0d spd=%0d mv=%0b want x=319 y=239 spd=1 mv=1",
               o_x, o_y, speed, moving);
    end
    frame();
    model_tick();
    set_sw(1, 0, 0, 0);
    frame();
    model_tick();
    total++;
    if (o_x !== 10'd318 || o_y !== 10'd237 || speed !== 3'd1 || o_y !== 10'(my)) begin
      bad++;
      $display("FAIL dir_change: got x=%0d y=%0d spd=%0d want x=318 y=237 spd=1",
               o_x, o_y, speed);
    end
    do_reset();
    set_sw(1, 0, 1, 0);
    frame();
    model_tick();
    set_sw(1, 0, 0, 0);
    frame();
    model_tick();
    total++;
    if (o_x !== 10'd319 || o_y !== 10'd238 || speed !== 3'd1 || moving !== 1'b1) begin
      bad++;
      $display("FAIL up_only: got x=%0d y=%0d spd=%0d mv=%0b want x=319 y=238 spd=1 mv=1",
               o_x, o_y, speed, moving);
    end
  endtask

  task automatic test_corner();
    do_reset();
    set_sw(1, 0, 1, 0);
    for (int i = 0; i < 110; i++) begin
      frame();
      model_tick();
      total++;
      if (o_x !== 10'(mx) || o_y !== 10'(my) || speed !== 3'(mspd)) begin
        bad++;
        $display("FAIL corner tick %0d: got x=%0d y=%0d spd=%0d want x=%0d y=%0d spd=%0d",
                 i, o_x, o_y, speed, mx, my, mspd);
      end
    end
    total++;
    if (o_x !== 10'd10 || o_y !== 10'd10) begin
      bad++;
      $display("FAIL corner_final: got x=%0d y=%0d want x=10 y=10", o_x, o_y);
    end
  endtask

  task automatic test_random();
    bit u, d, l, r;
    int nfr;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      u = ($urandom_range(0, 9) < 3);
      d = ($urandom_range(0, 9) < 3);
      l = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 9) < 4);
      set_sw(u, d, l, r);
      if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(0, 3)));
      nfr = int'($urandom_range(1, 4));
      for (int f = 0; f < nfr; f++) begin
        frame();
        model_tick();
        total++;
        if (o_x !== 10'(mx) || o_y !== 10'(my) || speed !== 3'(mspd) || moving !== (mheld > 0)) begin
          bad++;
          $display("FAIL random seg %0d frame %0d: got x=%0d y=%0d spd=%0d mv=%0b want x=%0d y=%0d spd=%0d mv=%0b",
                   s, f, o_x, o_y, speed, moving, mx, my, mspd, (mheld > 0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_sw(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      frame();
      model_tick();
    end
    total++;
    if (o_x !== 10'(mx) || speed !== 3'd3) begin
      bad++;
      $display("FAIL premid: got x=%0d spd=%0d want x=%0d spd=3", o_x, speed, mx);
    end
    // RST lands on the same edge the vsync tick would be applied
    @(negedge CLK);
    VS = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    right_switch = 1;
    model_reset();
    total++;
    if (o_x !== 10'd320 || o_y !== 10'd240 || speed !== 3'd0 || moving !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got x=%0d y=%0d spd=%0d mv=%0b want x=320 y=240 spd=0 mv=0",
               o_x, o_y, speed, moving);
    end
    repeat (8) @(negedge CLK);
    VS = 1;
    repeat (4) @(negedge CLK);
    total++;
    if (o_x !== 10'd320 || o_y !== 10'd240 || speed !== 3'd0 || moving !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_after: got x=%0d y=%0d spd=%0d mv=%0b want x=320 y=240 spd=0 mv=0",
               o_x, o_y, speed, moving);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bounce();
    test_ramp();
    test_clamp();
    test_diag();
    test_corner();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
